// File: rtl/stream_window_gen.sv
// stream_window_gen: raster pixel stream to KxK sliding window generator.
// Buffers KERNEL_SIZE-1 previous lines in a column-organised memory, keeps a
// KxK shift register of the most recent columns and emits one packed window
// per valid kernel position (respecting STRIDE) through a single-entry
// valid/ready output register.
module stream_window_gen #(
    parameter int PIXEL_WIDTH  = 9,
    parameter int KERNEL_SIZE  = 7,
    parameter int IMAGE_WIDTH  = 64,
    parameter int IMAGE_HEIGHT = 48,
    parameter int STRIDE       = 1
) (
    input  logic                                        clock,
    input  logic                                        reset,
    input  logic [PIXEL_WIDTH-1:0]                      pixel_in,
    input  logic                                        in_valid,
    input  logic                                        in_sof,
    output logic                                        in_ready,
    output logic [PIXEL_WIDTH*KERNEL_SIZE*KERNEL_SIZE-1:0] window_out,
    output logic [15:0]                                 out_x,
    output logic [15:0]                                 out_y,
    output logic                                        out_valid,
    input  logic                                        out_ready,
    output logic                                        frame_done
);

    localparam int K     = KERNEL_SIZE;
    localparam int PW    = PIXEL_WIDTH;
    localparam int COL_W = $clog2(IMAGE_WIDTH);
    localparam int ROW_W = $clog2(IMAGE_HEIGHT);
    localparam int LB_W  = PW * (K - 1);
    localparam int WIN_W = PW * K * K;

    // Raster position of the next pixel to be accepted.
    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;

    // Effective position of the pixel on the input (start-of-frame forces 0,0).
    logic [COL_W-1:0] cur_col;
    logic [ROW_W-1:0] cur_row;

    logic             accept;
    logic             emit;
    logic             last_pix;
    logic             col_last;
    logic             row_last;
    logic [31:0]      dx;
    logic [31:0]      dy;

    // Line memory: one entry per column holding that column's K-1 previous
    // lines, slot 0 (lowest bits) being the oldest line.
    logic [LB_W-1:0]  line_mem [IMAGE_WIDTH];
    logic [LB_W-1:0]  lb_rd;
    logic [LB_W-1:0]  lb_wr;

    // Window shift register, indexed [row][column], column K-1 newest.
    logic [PW-1:0]    win      [K][K];
    logic [PW-1:0]    win_next [K][K];
    logic [WIN_W-1:0] win_packed;

    assign accept   = in_valid && in_ready;
    assign in_ready = !out_valid || out_ready;

    // Resolve the effective pixel position and the emission decision.
    always_comb begin
        if (in_sof) begin
            cur_col = '0;
            cur_row = '0;
        end else begin
            cur_col = col;
            cur_row = row;
        end
        col_last = (cur_col == COL_W'(IMAGE_WIDTH - 1));
        row_last = (cur_row == ROW_W'(IMAGE_HEIGHT - 1));
        last_pix = col_last && row_last;
        dx       = 32'(cur_col) - 32'(K - 1);
        dy       = 32'(cur_row) - 32'(K - 1);
        if (accept && (32'(cur_col) >= 32'(K - 1)) && (32'(cur_row) >= 32'(K - 1)) &&
            ((dx % 32'(STRIDE)) == 32'd0) && ((dy % 32'(STRIDE)) == 32'd0)) begin
            emit = 1'b1;
        end else begin
            emit = 1'b0;
        end
    end

    // Read the buffered column and build its updated contents (drop oldest, append new pixel).
    always_comb begin
        lb_rd = line_mem[cur_col];
        lb_wr = '0;
        for (int s = 0; s < K - 2; s++) begin
            lb_wr[PW*s +: PW] = lb_rd[PW*(s+1) +: PW];
        end
        lb_wr[PW*(K-2) +: PW] = pixel_in;
    end

    // Next window: shift left one column, new right column from line memory plus pixel_in.
    always_comb begin
        for (int n = 0; n < K; n++) begin
            for (int m = 0; m < K - 1; m++) begin
                win_next[n][m] = win[n][m+1];
            end
        end
        for (int n = 0; n < K - 1; n++) begin
            win_next[n][K-1] = lb_rd[PW*n +: PW];
        end
        win_next[K-1][K-1] = pixel_in;
    end

    // Pack the next window: column m, row n at PW*(m + K*n).
    always_comb begin
        win_packed = '0;
        for (int n = 0; n < K; n++) begin
            for (int m = 0; m < K; m++) begin
                win_packed[PW*(m + K*n) +: PW] = win_next[n][m];
            end
        end
    end

    // Line memory write; contents are never reset because stale data is masked by the row check.
    always_ff @(posedge clock) begin
        if (accept) begin
            line_mem[cur_col] <= lb_wr;
        end
    end

    // Window shift register advances on every accepted pixel.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int n = 0; n < K; n++) begin
                for (int m = 0; m < K; m++) begin
                    win[n][m] <= '0;
                end
            end
        end else if (accept) begin
            win <= win_next;
        end
    end

    // Raster counters with line and frame wrap.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            col <= '0;
            row <= '0;
        end else if (accept) begin
            if (col_last) begin
                col <= '0;
                if (row_last) begin
                    row <= '0;
                end else begin
                    row <= cur_row + ROW_W'(1);
                end
            end else begin
                col <= cur_col + COL_W'(1);
                row <= cur_row;
            end
        end
    end

    // Frame-complete pulse, one cycle after the last pixel of the frame is accepted.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            frame_done <= 1'b0;
        end else begin
            frame_done <= accept && last_pix;
        end
    end

    // Single-entry output register: load on emission, clear when consumed, otherwise hold.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_valid  <= 1'b0;
            window_out <= '0;
            out_x      <= 16'd0;
            out_y      <= 16'd0;
        end else if (emit) begin
            out_valid  <= 1'b1;
            window_out <= win_packed;
            out_x      <= 16'(dx);
            out_y      <= 16'(dy);
        end else if (out_ready) begin
            out_valid  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_stream_window_gen.sv
// Self-checking bench for stream_window_gen (K=3, W=8, H=6): random flow
// control and pixel data compared against a frame-level window model.
module tb_stream_window_gen;

    localparam int PW = 9;
    localparam int K  = 3;
    localparam int W  = 8;
    localparam int H  = 6;
    localparam int WB = PW * K * K;

    typedef struct {
        int            x;
        int            y;
        logic [WB-1:0] w;
        int            cyc;
    } win_t;

    logic          clock = 1'b0;
    logic          reset;
    logic [PW-1:0] pixel_in;
    logic          in_valid;
    logic          in_sof;
    logic          in_ready;
    logic [WB-1:0] window_out;
    logic [15:0]   out_x;
    logic [15:0]   out_y;
    logic          out_valid;
    logic          out_ready;
    logic          frame_done;

    logic [PW-1:0] pixel_in_b;
    logic          in_valid_b;
    logic          in_sof_b;
    logic          in_ready_b;
    logic [WB-1:0] window_out_b;
    logic [15:0]   out_x_b;
    logic [15:0]   out_y_b;
    logic          out_valid_b;
    logic          out_ready_b;
    logic          frame_done_b;

    win_t got_q[$];
    win_t got2_q[$];
    win_t exp_q[$];
    int   acc_q[$];
    int   stim_pix[$];
    bit   stim_sof[$];
    int   frame_a[$];
    int   frame_b[$];
    int   ncyc = 0;
    int   fd_cnt = 0;
    int   fd_cyc = -1;
    int   checks = 0;
    int   errors = 0;

    always #5 clock = ~clock;

    stream_window_gen #(.PIXEL_WIDTH(PW), .KERNEL_SIZE(K), .IMAGE_WIDTH(W),
                        .IMAGE_HEIGHT(H), .STRIDE(1)) dut (
        .clock(clock), .reset(reset), .pixel_in(pixel_in), .in_valid(in_valid),
        .in_sof(in_sof), .in_ready(in_ready), .window_out(window_out),
        .out_x(out_x), .out_y(out_y), .out_valid(out_valid),
        .out_ready(out_ready), .frame_done(frame_done)
    );

    stream_window_gen #(.PIXEL_WIDTH(PW), .KERNEL_SIZE(K), .IMAGE_WIDTH(W),
                        .IMAGE_HEIGHT(H), .STRIDE(2)) dut_s2 (
        .clock(clock), .reset(reset), .pixel_in(pixel_in_b), .in_valid(in_valid_b),
        .in_sof(in_sof_b), .in_ready(in_ready_b), .window_out(window_out_b),
        .out_x(out_x_b), .out_y(out_y_b), .out_valid(out_valid_b),
        .out_ready(out_ready_b), .frame_done(frame_done_b)
    );

    // Record handshakes, accepts and frame_done pulses between clock edges.
    always @(negedge clock) begin
        if (!reset) begin
            if (out_valid && out_ready) got_q.push_back('{int'(out_x), int'(out_y), window_out, ncyc});
            if (in_valid && in_ready) acc_q.push_back(ncyc);
            if (frame_done) begin
                fd_cnt = fd_cnt + 1;
                fd_cyc = ncyc;
            end
            if (out_valid_b && out_ready_b) got2_q.push_back('{int'(out_x_b), int'(out_y_b), window_out_b, ncyc});
        end
        ncyc = ncyc + 1;
    end

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp_v);
        checks = checks + 1;
        if (obs !== exp_v) begin
            errors = errors + 1;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Reference: every kernel position of the frame whose bottom-right pixel
    // lies among the first npix pixels, in raster order of completion.
    function automatic void model_frame(input int pix[$], input int npix, input int stride);
        logic [WB-1:0] w;
        for (int y0 = 0; y0 <= H - K; y0 += stride) begin
            for (int x0 = 0; x0 <= W - K; x0 += stride) begin
                if ((y0 + K - 1) * W + x0 + K - 1 < npix) begin
                    w = '0;
                    for (int n = 0; n < K; n++)
                        for (int m = 0; m < K; m++)
                            w[PW*(m + K*n) +: PW] = PW'(pix[(y0 + n) * W + x0 + m]);
                    exp_q.push_back('{x0, y0, w, 0});
                end
            end
        end
    endfunction

    function automatic void make_frame(input bit pattern, output int f[$]);
        f = {};
        for (int i = 0; i < W * H; i++) f.push_back(pattern ? i : int'($urandom_range(511)));
    endfunction

    function automatic void add_stim(input int f[$], input int n, input bit sof);
        for (int i = 0; i < n; i++) begin
            stim_pix.push_back(f[i]);
            stim_sof.push_back(sof && (i == 0));
        end
    endfunction

    task automatic clear_all();
        got_q = {}; got2_q = {}; exp_q = {}; acc_q = {};
        stim_pix = {}; stim_sof = {};
        fd_cnt = 0; fd_cyc = -1;
    endtask

    task automatic compare_windows(input string tag);
        int n;
        check_eq($sformatf("%s_count", tag), 128'(got_q.size()), 128'(exp_q.size()));
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            check_eq($sformatf("%s_win%0d", tag, i),
                     {16'(got_q[i].x), 16'(got_q[i].y), got_q[i].w},
                     {16'(exp_q[i].x), 16'(exp_q[i].y), exp_q[i].w});
    endtask

    // Offer the stimulus queue to the STRIDE=1 instance with random gaps/back-pressure.
    task automatic drive(input int n, input int vpct, input int rpct, input bit do_stall, input int rst_at);
        int idx = 0;
        int guard = 0;
        int stall_left = 0;
        bit stall_done = 1'b0;
        bit stall_now;
        logic [127:0] snap = '0;
        while (idx < n && guard < 5000) begin
            @(posedge clock); #1;
            guard++;
            if (idx == rst_at) begin
                in_valid = 1'b0;
                check_eq("pre_reset_valid", 128'(out_valid), 128'(1));
                #2 reset = 1'b1;
                #1;
                check_eq("rst_out_valid", 128'(out_valid), 128'(0));
                check_eq("rst_window", 128'(window_out), 128'(0));
                check_eq("rst_xy", {out_x, out_y}, 128'(0));
                check_eq("rst_in_ready", 128'(in_ready), 128'(1));
                @(negedge clock); #1;
                reset = 1'b0;
                return;
            end
            stall_now = 1'b0;
            if (stall_left > 0) begin
                stall_left--;
                stall_now = 1'b1;
            end else if (do_stall && !stall_done && out_valid) begin
                stall_left = 9;
                stall_now  = 1'b1;
                stall_done = 1'b1;
                snap = 128'({window_out, out_x, out_y});
            end
            out_ready = stall_now ? 1'b0 : ($urandom_range(99) < rpct);
            in_valid  = ($urandom_range(99) < vpct);
            pixel_in  = PW'(stim_pix[idx]);
            in_sof    = stim_sof[idx];
            @(negedge clock);
            if (stall_now) begin
                check_eq("stall_in_ready", 128'(in_ready), 128'(0));
                check_eq("stall_hold", 128'({window_out, out_x, out_y}), snap);
            end
            if (in_valid && in_ready) idx++;
        end
        if (idx < n) check_eq("drive_timeout", 128'(idx), 128'(n));
        for (int i = 0; i < 20; i++) begin
            @(posedge clock); #1;
            in_valid = 1'b0; in_sof = 1'b0; out_ready = 1'b1;
        end
    endtask

    initial begin
        reset = 1'b1;
        pixel_in = '0; in_valid = 1'b0; in_sof = 1'b0; out_ready = 1'b1;
        pixel_in_b = '0; in_valid_b = 1'b0; in_sof_b = 1'b0; out_ready_b = 1'b1;
        repeat (2) @(negedge clock);
        check_eq("reset_out_valid", 128'(out_valid), 128'(0));
        check_eq("reset_window", 128'(window_out), 128'(0));
        check_eq("reset_xy", {out_x, out_y}, 128'(0));
        check_eq("reset_frame_done", 128'(frame_done), 128'(0));
        #1 reset = 1'b0;
        @(negedge clock);
        check_eq("reset_in_ready", 128'(in_ready), 128'(1));

        // Full-rate frame, pattern pixels.
        clear_all();
        make_frame(1'b1, frame_a);
        add_stim(frame_a, W * H, 1'b1);
        drive(W * H, 100, 100, 1'b0, -1);
        model_frame(frame_a, W * H, 1);
        compare_windows("t1");
        check_eq("t1_latency", 128'(got_q.size() > 0 ? got_q[0].cyc : -1),
                 128'(acc_q.size() > 18 ? acc_q[18] + 1 : -2));
        if (got_q.size() > 0) begin
            check_eq("t1_e00", 128'(got_q[0].w[0 +: PW]), 128'(0));
            check_eq("t1_e20", 128'(got_q[0].w[PW*2 +: PW]), 128'(2));
            check_eq("t1_e02", 128'(got_q[0].w[PW*6 +: PW]), 128'(16));
            check_eq("t1_e22", 128'(got_q[0].w[PW*8 +: PW]), 128'(18));
        end
        check_eq("t1_fd_count", 128'(fd_cnt), 128'(1));
        check_eq("t1_fd_cycle", 128'(fd_cyc), 128'(acc_q.size() > 47 ? acc_q[47] + 1 : -2));

        // STRIDE=2 instance, same frame.
        clear_all();
        for (int i = 0; i < W * H; i++) begin
            @(posedge clock); #1;
            in_valid_b = 1'b1; pixel_in_b = PW'(frame_a[i]); in_sof_b = (i == 0);
        end
        @(posedge clock); #1;
        in_valid_b = 1'b0; in_sof_b = 1'b0;
        repeat (5) @(posedge clock);
        #1;
        got_q = got2_q;
        model_frame(frame_a, W * H, 2);
        compare_windows("t2");
        begin
            int hit = -1;
            foreach (got_q[i]) if (got_q[i].x == 4 && got_q[i].y == 2) hit = i;
            check_eq("t2_win42_e00", 128'(hit >= 0 ? int'(got_q[hit].w[0 +: PW]) : -1), 128'(20));
        end

        // Output stall for 10 cycles while a window is held.
        clear_all();
        add_stim(frame_a, W * H, 1'b1);
        drive(W * H, 100, 100, 1'b1, -1);
        model_frame(frame_a, W * H, 1);
        compare_windows("t3");

        // Random gaps and random back-pressure, random pixel data, two frames.
        clear_all();
        make_frame(1'b0, frame_a);
        make_frame(1'b0, frame_b);
        add_stim(frame_a, W * H, 1'b1);
        add_stim(frame_b, W * H, 1'b1);
        drive(2 * W * H, 50, 50, 1'b0, -1);
        model_frame(frame_a, W * H, 1);
        model_frame(frame_b, W * H, 1);
        compare_windows("t4");
        check_eq("t4_fd_count", 128'(fd_cnt), 128'(2));

        // Start-of-frame at pixel (3,4) abandons the partial frame.
        clear_all();
        make_frame(1'b1, frame_a);
        make_frame(1'b0, frame_b);
        add_stim(frame_a, 4 * W + 3, 1'b1);
        add_stim(frame_b, W * H, 1'b1);
        drive(4 * W + 3 + W * H, 80, 80, 1'b0, -1);
        model_frame(frame_a, 4 * W + 3, 1);
        model_frame(frame_b, W * H, 1);
        compare_windows("t5");
        check_eq("t5_fd_count", 128'(fd_cnt), 128'(1));

        // Reset at pixel (5,3), then a frame without start-of-frame marker.
        clear_all();
        add_stim(frame_a, W * H, 1'b1);
        drive(W * H, 100, 100, 1'b0, 3 * W + 5);
        clear_all();
        make_frame(1'b0, frame_b);
        add_stim(frame_b, W * H, 1'b0);
        drive(W * H, 100, 100, 1'b0, -1);
        model_frame(frame_b, W * H, 1);
        compare_windows("t6");
        check_eq("t6_fd_count", 128'(fd_cnt), 128'(1));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/stream_window_gen.md
Name: stream_window_gen

Overview:
- Parametrised successor to the fixed 7x7 shifting-window/selector pair.
- Accepts a raster-order pixel stream with valid/ready flow control and buffers KERNEL_SIZE-1 image lines.
- Emits one packed KERNEL_SIZE x KERNEL_SIZE window per valid kernel position, honouring STRIDE.
- Sits between the camera/pixel source and the convolution multiplier array.

Parameters:
PIXEL_WIDTH, 9, bits per pixel
KERNEL_SIZE, 7, window edge length (>=2)
IMAGE_WIDTH, 64, pixels per line (> KERNEL_SIZE)
IMAGE_HEIGHT, 48, lines per frame (>= KERNEL_SIZE)
STRIDE, 1, step between emitted windows in x and y (1..KERNEL_SIZE)

Ports:
clock  in  1  single clock, rising edge
reset  in  1  asynchronous, active-high
pixel_in  in  PIXEL_WIDTH  raster-order pixel
in_valid  in  1  pixel_in valid
in_sof  in  1  start of frame, qualified by in_valid; marks pixel (0,0)
in_ready  out  1  block can accept pixel this cycle
window_out  out  PIXEL_WIDTH*KERNEL_SIZE*KERNEL_SIZE  packed window
out_x  out  16  top-left column of window_out
out_y  out  16  top-left row of window_out
out_valid  out  1  window_out/out_x/out_y valid
out_ready  in  1  consumer accepts window
frame_done  out  1  one-cycle pulse when last pixel of frame accepted

Behaviour:
- Reset (async, active-high): out_valid=0, window_out=0, out_x=0, out_y=0, frame_done=0, column/row counters=0. in_ready=1 after reset. Line-buffer RAM is not reset; its stale contents are never emitted.
- Accept = in_valid && in_ready. in_ready = !out_valid || out_ready (single-entry output register; no accept while a window is stalled).
- On accept: pixel is written into the line buffer at the current column; the KxK shift register shifts left one column, loading the new right column from the K-1 line-buffer outputs (oldest line at row 0) plus pixel_in (row K-1). Column counter col increments; at IMAGE_WIDTH-1 it wraps to 0 and row increments; at (IMAGE_WIDTH-1, IMAGE_HEIGHT-1) both wrap to 0 and frame_done pulses on the following cycle.
- Window emission: on accepting pixel (col,row) with col>=K-1, row>=K-1, (col-(K-1)) mod STRIDE==0 and (row-(K-1)) mod STRIDE==0, the next cycle asserts out_valid with out_x=col-(K-1), out_y=row-(K-1). Latency: 1 cycle from completing pixel accept to out_valid.
- Windows never span a line boundary: the shift register contents from the previous line are masked by the col>=K-1 condition.
- out_valid holds with window_out/out_x/out_y stable until out_valid && out_ready. A new window may load in the same cycle the old one is consumed (full throughput: one pixel per clock with out_ready=1).
- Packing: element at column m (0=leftmost), row n (0=top) occupies bits [PIXEL_WIDTH*(m+KERNEL_SIZE*n) +: PIXEL_WIDTH].
- in_sof with accept: counters forced so the pixel is treated as (0,0); any pending out_valid is not discarded. in_sof mid-frame silently abandons the partial frame (no frame_done).
- Windows per frame = (floor((IMAGE_WIDTH-K)/STRIDE)+1) * (floor((IMAGE_HEIGHT-K)/STRIDE)+1).
- Reset mid-frame: all state returns to reset values immediately; next accepted pixel is (0,0) regardless of in_sof.
- Counter widths: clog2 of IMAGE_WIDTH/IMAGE_HEIGHT internally, zero-extended to 16 on out_x/out_y.

Test Plan (K=3, W=8, H=6, pixel value = 8*y+x unless noted):
- Stream one frame, out_ready=1, STRIDE=1 -> first out_valid one cycle after 19th pixel (x=2,y=2) accepted, out_x=0,out_y=0, elements (0,0)=0,(2,0)=2,(0,2)=16,(2,2)=18; exactly 24 windows; frame_done one pulse after pixel 47.
- Same frame, STRIDE=2 -> exactly 6 windows, coordinates (0,0),(2,0),(4,0),(0,2),(2,2),(4,2); window (4,2) element (0,0)=20.
- out_ready=0 for 10 cycles while valid window held -> in_ready=0, window_out/out_x/out_y unchanged, no pixel lost; after release all 24 windows still arrive in order.
- Random in_valid gaps (50%) and random out_ready -> window sequence and contents identical to the gap-free run.
- in_sof asserted at pixel (3,4) of frame 1, then full frame -> no frame_done for frame 1; next 24 windows match fresh-frame values.
- Assert reset at pixel (5,3) -> out_valid=0, window_out=0 asynchronously; following frame yields the 24 correct windows.
